// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: resolves memory waits, jump flushes and
// load-use hazards with fixed priority, and keeps stall statistics.
module pipeline_hazard_ctrl #(
  parameter int unsigned JUMP_FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 64,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       ID_RS,
  input  logic [4:0]       ID_RT,
  input  logic             ID_uses_rt,
  input  logic             EX_MEM_REN,
  input  logic [4:0]       EX_RT,
  input  logic             EX_PC_jump,
  input  logic             MEM_access,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout,
  output logic [1:0]       state_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StJflush  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        jcnt_q, jcnt_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              timeout_q, timeout_d;

  logic lu, mw;

  assign lu = EX_MEM_REN && (EX_RT != 5'd0) &&
              ((EX_RT == ID_RS) || (ID_uses_rt && (EX_RT == ID_RT)));
  assign mw = MEM_access && !mem_ack;

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b0;
    if (!reset && !mw) begin
      if (state_q == StJflush || EX_PC_jump) begin
        // Ongoing flush overrides load-use: the ID instruction is discarded anyway.
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_write = 1'b1;
      end else if (lu) begin
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_write = 1'b1;
      end else begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    jcnt_d    = jcnt_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    stall_d   = stall_q;
    if ((!pc_write || if_id_flush) && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    case (state_q)
      StJflush: begin
        if (!mw) begin
          jcnt_d = jcnt_q - 4'd1;
          if (jcnt_q == 4'd1) state_d = StRun;
        end
      end
      default: begin
        if (mw) begin
          state_d = StMemWait;
          if (state_q == StRun) begin
            wcnt_d = WAIT_W'(1);
          end else if (wcnt_q != WAIT_MAX) begin
            wcnt_d = wcnt_q + WAIT_W'(1);
          end
          if (wcnt_d == WAIT_MAX) timeout_d = 1'b1;
        end else begin
          // An acked MEM_WAIT cycle follows exactly the RUN rules.
          state_d = StRun;
          wcnt_d  = '0;
          if (EX_PC_jump && (JUMP_FLUSH_CYCLES > 1)) begin
            state_d = StJflush;
            jcnt_d  = 4'(JUMP_FLUSH_CYCLES - 1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StRun;
      jcnt_q    <= '0;
      wcnt_q    <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      jcnt_q    <= jcnt_d;
      wcnt_q    <= wcnt_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_cycles = stall_q;
  assign mem_timeout  = timeout_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed sequences, a vector table and
// randomized traffic checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int JFC = 3;
  localparam int MT  = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_ren, ex_pc_jump, mem_access, mem_ack;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write;
  logic [15:0] stall_cycles;
  logic        mem_timeout;
  logic [1:0]  state_o;

  pipeline_hazard_ctrl #(
    .JUMP_FLUSH_CYCLES(JFC),
    .MEM_TIMEOUT      (MT),
    .CNT_W            (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ID_RS       (id_rs),
    .ID_RT       (id_rt),
    .ID_uses_rt  (id_uses_rt),
    .EX_MEM_REN  (ex_mem_ren),
    .EX_RT       (ex_rt),
    .EX_PC_jump  (ex_pc_jump),
    .MEM_access  (mem_access),
    .mem_ack     (mem_ack),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .id_ex_write (id_ex_write),
    .id_ex_flush (id_ex_flush),
    .ex_mem_write(ex_mem_write),
    .stall_cycles(stall_cycles),
    .mem_timeout (mem_timeout),
    .state_o     (state_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       ren;
    logic [4:0] ex_rt;
    logic       jump;
    logic       acc;
    logic       ack;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [5:0] exp;  // {pc, ifw, iff, idw, idf, exw}
  } vec_t;

  localparam logic [5:0] C_NORM  = 6'b110101;
  localparam logic [5:0] C_LU    = 6'b000111;
  localparam logic [5:0] C_JUMP  = 6'b111111;
  localparam logic [5:0] C_FRZ   = 6'b000000;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: remaining flush cycles, consecutive wait cycles, stall tally.
  int m_flush_left, m_wait, m_stall;
  bit m_to;

  logic [5:0]  obs_ctrl;
  logic [1:0]  obs_state;
  logic [15:0] obs_stall;
  logic        obs_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic in_t mk(int rs, int rt, bit urt, bit ren, int ert, bit j, bit a, bit k);
    in_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.urt = urt; v.ren = ren; v.ex_rt = 5'(ert);
    v.jump = j; v.acc = a; v.ack = k;
    return v;
  endfunction

  function automatic logic [5:0] model_ctrl(in_t v);
    bit mw, lu;
    mw = v.acc && !v.ack;
    lu = v.ren && v.ex_rt != 0 && (v.ex_rt == v.rs || (v.urt && v.ex_rt == v.rt));
    if (mw) return C_FRZ;
    if (m_flush_left > 0 || v.jump) return C_JUMP;
    if (lu) return C_LU;
    return C_NORM;
  endfunction

  task automatic model_reset();
    m_flush_left = 0; m_wait = 0; m_stall = 0; m_to = 0;
  endtask

  task automatic model_update(in_t v, logic [5:0] c);
    bit mw;
    mw = v.acc && !v.ack;
    if (!c[5] || c[3]) m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
    if (m_flush_left > 0) begin
      if (!mw) m_flush_left--;
    end else if (mw) begin
      if (m_wait < MT) m_wait++;
      if (m_wait == MT) m_to = 1;
    end else begin
      m_wait = 0;
      if (v.jump && JFC > 1) m_flush_left = JFC - 1;
    end
  endtask

  function automatic int model_state();
    if (m_flush_left > 0) return 2;
    if (m_wait > 0) return 1;
    return 0;
  endfunction

  task automatic set_inputs(in_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.urt; ex_mem_ren = v.ren;
    ex_rt = v.ex_rt; ex_pc_jump = v.jump; mem_access = v.acc; mem_ack = v.ack;
  endtask

  // Apply one cycle of inputs, compare against the model mid-cycle, then advance.
  task automatic drive(in_t v);
    logic [5:0] exp_c;
    set_inputs(v);
    @(negedge clock);
    obs_ctrl  = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write};
    obs_state = state_o;
    obs_stall = stall_cycles;
    obs_to    = mem_timeout;
    exp_c = model_ctrl(v);
    check("model_ctrl", 32'(obs_ctrl), 32'(exp_c));
    check("model_state", 32'(obs_state), 32'(model_state()));
    check("model_stall", 32'(obs_stall), 32'(m_stall));
    check("model_timeout", 32'(obs_to), 32'(m_to));
    model_update(v, exp_c);
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                               ex_mem_write}), 32'(C_FRZ));
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_stall"}, 32'(stall_cycles), 32'd0);
    check({tag, "_timeout"}, 32'(mem_timeout), 32'd0);
  endtask

  // Reset pulse within a cycle, starting just after a rising edge.
  task automatic mid_cycle_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_all_zero(tag);
    set_inputs('0);
    reset = 1'b0;
    model_reset();
  endtask

  vec_t table_v[8];
  in_t  idle;
  in_t  r;

  initial begin
    idle = '0;
    set_inputs(idle);
    reset = 1'b1;
    model_reset();
    #12 check_all_zero("reset");
    set_inputs(mk(5, 0, 0, 1, 5, 0, 0, 0));
    #1 check_all_zero("reset_lu_inputs");
    set_inputs(idle);
    reset = 1'b0;
    @(posedge clock); #1;

    // Load-use, then the bubble clears it.
    drive(mk(5, 0, 0, 1, 5, 0, 0, 0));
    check("lu_ctrl", 32'(obs_ctrl), 32'(C_LU));
    drive(idle);
    check("lu_after_ctrl", 32'(obs_ctrl), 32'(C_NORM));
    check("lu_stall", 32'(obs_stall), 32'd1);
    drive(mk(0, 5, 0, 1, 5, 0, 0, 0));
    check("rt_unused_ctrl", 32'(obs_ctrl), 32'(C_NORM));
    drive(mk(0, 0, 1, 1, 0, 0, 0, 0));
    check("zero_reg_ctrl", 32'(obs_ctrl), 32'(C_NORM));
    drive(idle);
    check("zero_reg_stall", 32'(obs_stall), 32'd1);

    // Jump with simultaneous load-use: three flush cycles, no hold.
    drive(mk(5, 0, 0, 1, 5, 1, 0, 0));
    check("jump0_ctrl", 32'(obs_ctrl), 32'(C_JUMP));
    check("jump0_state", 32'(obs_state), 32'd0);
    drive(mk(5, 0, 0, 1, 5, 0, 0, 0));
    check("jump1_ctrl", 32'(obs_ctrl), 32'(C_JUMP));
    check("jump1_state", 32'(obs_state), 32'd2);
    drive(idle);
    check("jump2_ctrl", 32'(obs_ctrl), 32'(C_JUMP));
    check("jump2_state", 32'(obs_state), 32'd2);
    drive(idle);
    check("jump3_ctrl", 32'(obs_ctrl), 32'(C_NORM));
    check("jump3_state", 32'(obs_state), 32'd0);
    check("jump_stall", 32'(obs_stall), 32'd4);

    // Memory wait of 4 cycles, then ack.
    for (int i = 0; i < 4; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 1, 0));
      check("memwait_ctrl", 32'(obs_ctrl), 32'(C_FRZ));
      check("memwait_state", 32'(obs_state), (i == 0) ? 32'd0 : 32'd1);
    end
    drive(mk(0, 0, 0, 0, 0, 0, 1, 1));
    check("memack_ctrl", 32'(obs_ctrl), 32'(C_NORM));
    check("memack_state", 32'(obs_state), 32'd1);
    drive(idle);
    check("memdone_state", 32'(obs_state), 32'd0);
    check("memdone_stall", 32'(obs_stall), 32'd8);

    // Timeout after the 8th wait cycle, sticky across the ack.
    for (int i = 0; i < 10; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 1, 0));
      check("timeout_rise", 32'(obs_to), (i >= 8) ? 32'd1 : 32'd0);
    end
    drive(mk(0, 0, 0, 0, 0, 0, 1, 1));
    check("timeout_sticky_ack", 32'(obs_to), 32'd1);
    drive(idle);
    check("timeout_sticky_idle", 32'(obs_to), 32'd1);

    // Asynchronous reset in the middle of a memory wait.
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0));
    set_inputs(mk(0, 0, 0, 0, 0, 0, 1, 0));
    mid_cycle_reset("rst_memwait");
    drive(idle);

    // Single-cycle control decode from RUN.
    table_v[0] = '{in: mk(0, 0, 0, 0, 0, 0, 0, 0), exp: C_NORM};
    table_v[1] = '{in: mk(7, 0, 0, 1, 7, 0, 0, 0), exp: C_LU};
    table_v[2] = '{in: mk(2, 9, 1, 1, 9, 0, 0, 0), exp: C_LU};
    table_v[3] = '{in: mk(2, 9, 0, 1, 9, 0, 0, 0), exp: C_NORM};
    table_v[4] = '{in: mk(0, 0, 1, 1, 0, 0, 0, 0), exp: C_NORM};
    table_v[5] = '{in: mk(3, 3, 1, 0, 3, 0, 0, 0), exp: C_NORM};
    table_v[6] = '{in: mk(31, 0, 0, 1, 31, 0, 1, 1), exp: C_LU};
    table_v[7] = '{in: mk(4, 0, 0, 0, 0, 0, 0, 1), exp: C_NORM};
    for (int i = 0; i < 8; i++) begin
      drive(table_v[i].in);
      check($sformatf("table%0d_ctrl", i), 32'(obs_ctrl), 32'(table_v[i].exp));
    end
    drive(idle);
    check("table_stall", 32'(obs_stall), 32'd3);

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 1500; i++) begin
      r.rs    = 5'($urandom_range(0, 3));
      r.rt    = 5'($urandom_range(0, 3));
      r.urt   = 1'($urandom_range(0, 1));
      r.ren   = ($urandom_range(0, 9) < 4);
      r.ex_rt = 5'($urandom_range(0, 3));
      r.jump  = ($urandom_range(0, 9) == 0);
      r.acc   = ($urandom_range(0, 9) < 4);
      r.ack   = ($urandom_range(0, 9) < 3);
      drive(r);
      if (i % 300 == 299) begin
        set_inputs(r);
        mid_cycle_reset("rst_random");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
